// File: rtl/engine_dispatcher_pkg.sv
// Shared fractal package: frame defaults, coordinate widths and dispatcher FSM encoding.
package engine_dispatcher_pkg;

  localparam int X_SIZE_DEF = 640;
  localparam int Y_SIZE_DEF = 480;
  localparam int X_W        = 10;
  localparam int Y_W        = 9;
  localparam int C_W        = 32;
  localparam int CNT_W      = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } disp_state_t;

endpackage

// File: rtl/engine_dispatcher_rr_select.sv
// Round-robin free-engine selector: first free engine at or after ptr, wrapping modulo N.
module rr_select #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     free,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  // Scan offsets 0..N-1 from ptr; the first free engine found wins.
  always_comb begin : scan
    logic hit_s;
    grant = '0;
    valid = 1'b0;
    hit_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        hit_s    = !valid && free[j] && (j == ((int'(ptr) + i) % N));
        grant[j] = grant[j] | hit_s;
        valid    = valid | hit_s;
      end
    end
  end

endmodule

// File: rtl/engine_dispatcher.sv
// Pixel job dispatcher for NUM_ENG iteration engines with round-robin grant.
// Optional stall counter output perf_stall when DISPATCH_PERF_EN is defined.
module engine_dispatcher
  import engine_dispatcher_pkg::*;
#(
  parameter int NUM_ENG = 4,
  parameter int X_SIZE  = X_SIZE_DEF,
  parameter int Y_SIZE  = Y_SIZE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [X_W-1:0]     in_x,
  input  logic [Y_W-1:0]     in_y,
  input  logic [C_W-1:0]     in_cr,
  input  logic [C_W-1:0]     in_ci,
  output logic [NUM_ENG-1:0] eng_start,
  output logic [X_W-1:0]     eng_x,
  output logic [Y_W-1:0]     eng_y,
  output logic [C_W-1:0]     eng_cr,
  output logic [C_W-1:0]     eng_ci,
  input  logic [NUM_ENG-1:0] eng_done,
  output logic               busy,
  output logic               frame_done
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]        perf_stall
`endif
);

  localparam int PTR_W = (NUM_ENG > 2) ? $clog2(NUM_ENG) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(X_SIZE * Y_SIZE - 1);

  disp_state_t        state_r, state_s;
  logic [NUM_ENG-1:0] busy_r, free_s, grant_s;
  logic               grant_valid_s, accept_s, last_pix_s;
  logic [PTR_W-1:0]   ptr_r, ptr_s;
  logic [CNT_W-1:0]   cnt_r;

  assign free_s     = ~busy_r;
  assign in_ready   = (state_r == ST_RUN) && grant_valid_s;
  assign accept_s   = in_valid && in_ready;
  assign last_pix_s = (cnt_r == LAST_PIX);
  assign busy       = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign frame_done = (state_r == ST_DONE);

  rr_select #(
    .N     (NUM_ENG),
    .PTR_W (PTR_W)
  ) u_rr_select (
    .free  (free_s),
    .ptr   (ptr_r),
    .grant (grant_s),
    .valid (grant_valid_s)
  );

  // Pointer after a grant: one past the granted engine, wrapping.
  always_comb begin
    ptr_s = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      ptr_s = ptr_s | ({PTR_W{grant_s[i]}} & PTR_W'((i + 1) % NUM_ENG));
    end
  end

  // Frame FSM next state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_RUN;
        else       state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (accept_s && last_pix_s) state_s = ST_DRAIN;
        else                        state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (busy_r == '0) state_s = ST_DONE;
        else              state_s = ST_DRAIN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Frame FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Engine reservation happens at acceptance so the next cycle cannot re-grant it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= '0;
      ptr_r  <= '0;
      cnt_r  <= '0;
    end else begin
      busy_r <= (busy_r & ~eng_done) | (accept_s ? grant_s : '0);
      if (accept_s) ptr_r <= ptr_s;
      else          ptr_r <= ptr_r;
      if (state_r == ST_IDLE && start) cnt_r <= '0;
      else if (accept_s)               cnt_r <= cnt_r + CNT_W'(1);
      else                             cnt_r <= cnt_r;
    end
  end

  // Job launch one cycle after acceptance; payload holds until the next launch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_start <= '0;
      eng_x     <= '0;
      eng_y     <= '0;
      eng_cr    <= '0;
      eng_ci    <= '0;
    end else begin
      eng_start <= accept_s ? grant_s : '0;
      if (accept_s) begin
        eng_x  <= in_x;
        eng_y  <= in_y;
        eng_cr <= in_cr;
        eng_ci <= in_ci;
      end
    end
  end

`ifdef DISPATCH_PERF_EN
  // Saturating count of RUN cycles where the generator was held off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     perf_stall <= 32'd0;
    else if (state_r == ST_IDLE && start)          perf_stall <= 32'd0;
    else if (state_r == ST_RUN && in_valid && !in_ready && perf_stall != 32'hFFFF_FFFF)
                                                   perf_stall <= perf_stall + 32'd1;
    else                                           perf_stall <= perf_stall;
  end
`endif

endmodule

// File: tb/tb_engine_dispatcher.sv
// Randomized bench for engine_dispatcher against a cycle-level behavioural model.
module tb_engine_dispatcher;

  localparam int NE    = 4;
  localparam int XS    = 4;
  localparam int YS    = 2;
  localparam int TOTAL = XS * YS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [9:0]    in_x = '0;
  logic [8:0]    in_y = '0;
  logic [31:0]   in_cr = '0;
  logic [31:0]   in_ci = '0;
  logic [NE-1:0] eng_start;
  logic [9:0]    eng_x;
  logic [8:0]    eng_y;
  logic [31:0]   eng_cr;
  logic [31:0]   eng_ci;
  logic [NE-1:0] eng_done = '0;
  logic          busy;
  logic          frame_done;
`ifdef DISPATCH_PERF_EN
  logic [31:0]   perf_stall;
`endif

  always #5 clk = ~clk;

  engine_dispatcher #(.NUM_ENG(NE), .X_SIZE(XS), .Y_SIZE(YS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_cr      (in_cr),
    .in_ci      (in_ci),
    .eng_start  (eng_start),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_cr     (eng_cr),
    .eng_ci     (eng_ci),
    .eng_done   (eng_done),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef DISPATCH_PERF_EN
    ,
    .perf_stall (perf_stall)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 run, 2 drain, 3 done
  int            m_phase;
  bit            m_busy [NE];
  int            m_ptr;
  int            m_cnt;
  logic [NE-1:0] m_start;
  logic [82:0]   m_pay;
  logic [31:0]   m_perf;
  int            rem [NE];
  int            launches;
  int            lat_lo, lat_hi, p_spur;

  task automatic model_reset();
    m_phase = 0;
    for (int e = 0; e < NE; e++) m_busy[e] = 1'b0;
    m_ptr   = 0;
    m_cnt   = 0;
    m_start = '0;
    m_pay   = '0;
    m_perf  = 32'd0;
  endtask

  task automatic cycle(input bit rst_now, input int pv, input int ps);
    logic [NE-1:0] done;
    bit            exp_rdy, any_free, all_idle, accept;
    int            g, e;
    @(posedge clk);
    #1;
    done = '0;
    for (int k = 0; k < NE; k++) begin
      if (rem[k] > 0) begin
        rem[k]--;
        if (rem[k] == 0) done[k] = 1'b1;
      end else if (!m_busy[k] && $urandom_range(99) < p_spur) begin
        done[k] = 1'b1;
      end
    end
    if (rst_now) model_reset();
    for (int k = 0; k < NE; k++)
      if (m_start[k]) rem[k] = $urandom_range(lat_hi, lat_lo);
    reset    = rst_now;
    start    = ($urandom_range(99) < ps);
    in_valid = ($urandom_range(99) < pv);
    in_x     = 10'($urandom);
    in_y     = 9'($urandom);
    in_cr    = $urandom;
    in_ci    = $urandom;
    eng_done = done;
    @(negedge clk);
    any_free = 1'b0;
    all_idle = 1'b1;
    for (int k = 0; k < NE; k++) begin
      if (!m_busy[k]) any_free = 1'b1;
      if (m_busy[k])  all_idle = 1'b0;
    end
    exp_rdy = (m_phase == 1) && any_free;
    launches += $countones(eng_start);
    check_eq("in_ready", in_ready, exp_rdy);
    check_eq("busy", busy, (m_phase == 1) || (m_phase == 2));
    check_eq("frame_done", frame_done, m_phase == 3);
    check_eq("eng_start", eng_start, m_start);
    check_eq("payload", {eng_x, eng_y, eng_cr, eng_ci}, m_pay);
`ifdef DISPATCH_PERF_EN
    check_eq("perf_stall", perf_stall, m_perf);
`endif
    if (m_phase == 3) check_eq("launches", launches, TOTAL);
    if (!rst_now) begin
      accept = in_valid && exp_rdy;
      g = -1;
      for (int k = 0; k < NE; k++) begin
        e = (m_ptr + k) % NE;
        if (accept && g < 0 && !m_busy[e]) g = e;
      end
      if (m_phase == 0 && start) m_perf = 32'd0;
      else if (m_phase == 1 && in_valid && !exp_rdy && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
      case (m_phase)
        0: if (start) begin m_phase = 1; m_cnt = 0; launches = 0; end
        1: if (accept) begin m_cnt++; if (m_cnt == TOTAL) m_phase = 2; end
        2: if (all_idle) m_phase = 3;
        default: m_phase = 0;
      endcase
      for (int k = 0; k < NE; k++) if (done[k]) m_busy[k] = 1'b0;
      m_start = '0;
      if (accept) begin
        m_busy[g]  = 1'b1;
        m_start[g] = 1'b1;
        m_pay      = {in_x, in_y, in_cr, in_ci};
        m_ptr      = (g + 1) % NE;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NE; k++) rem[k] = 0;
    launches = 0;
    model_reset();
    lat_lo = 20; lat_hi = 20; p_spur = 0;
    cycle(1'b1, 0, 0);
    cycle(1'b1, 0, 0);
    // Back-to-back grants with long jobs, then stall, then finish the frame
    cycle(1'b0, 0, 100);
    repeat (70) cycle(1'b0, 100, 0);
    // Reset in the middle of a frame with engines busy, then restart
    lat_lo = 10; lat_hi = 10;
    cycle(1'b0, 0, 100);
    repeat (4) cycle(1'b0, 100, 0);
    cycle(1'b1, 100, 100);
    cycle(1'b0, 100, 0);
    cycle(1'b0, 0, 100);
    repeat (60) cycle(1'b0, 100, 0);
    // Random traffic with starts during RUN, spurious dones and occasional resets
    lat_lo = 1; lat_hi = 6; p_spur = 5;
    for (int n = 0; n < 1500; n++)
      cycle($urandom_range(299) == 0, 70, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
